reg_writeback: RTL

Writeback sequencer that sits in front of the MIPS register file and is the only source of its write port (write_ena, write-register address, write_data). It merges single-cycle ALU results with out-of-order-timed load returns into one register-file write per cycle. It keeps a 32-entry busy scoreboard of outstanding loads, which the decode stage queries, and drives a one-cycle forwarding path for the value being written.

---
 rtl/reg_writeback_pkg.sv | 13 +
 rtl/wb_alu_fifo.sv | 43 ++++
 rtl/reg_writeback.sv | 92 +++++++++
 3 files changed

// File: rtl/reg_writeback_pkg.sv
// reg_writeback_pkg: shared register-file widths and MIPS register numbers
package reg_writeback_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [4:0] REG_ZERO = 5'd0, REG_AT = 5'd1, REG_V0 = 5'd2, REG_V1 = 5'd3;
  localparam logic [4:0] REG_A0 = 5'd4, REG_A1 = 5'd5, REG_A2 = 5'd6, REG_A3 = 5'd7;
  localparam logic [4:0] REG_T0 = 5'd8, REG_T1 = 5'd9, REG_T2 = 5'd10, REG_T3 = 5'd11;
  localparam logic [4:0] REG_T4 = 5'd12, REG_T5 = 5'd13, REG_T6 = 5'd14, REG_T7 = 5'd15;
  localparam logic [4:0] REG_S0 = 5'd16, REG_S1 = 5'd17, REG_S2 = 5'd18, REG_S3 = 5'd19;
  localparam logic [4:0] REG_S4 = 5'd20, REG_S5 = 5'd21, REG_S6 = 5'd22, REG_S7 = 5'd23;
  localparam logic [4:0] REG_T8 = 5'd24, REG_T9 = 5'd25, REG_K0 = 5'd26, REG_K1 = 5'd27;
  localparam logic [4:0] REG_GP = 5'd28, REG_SP = 5'd29, REG_FP = 5'd30, REG_RA = 5'd31;
endpackage

// File: rtl/wb_alu_fifo.sv
// wb_alu_fifo: small synchronous FIFO exposing per-slot valid bits and storage for hazard lookup
module wb_alu_fifo #(
  parameter int W = 37,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [W-1:0]       data_i,
  output logic [W-1:0]       data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [DEPTH-1:0]   valid_o,
  output logic [DEPTH*W-1:0] mem_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr_q, rptr_q, count;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] off;
  assign count = wptr_q - rptr_q;
  assign empty_o = wptr_q == rptr_q;
  assign full_o = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign data_o = mem_q[rptr_q[AW-1:0]];
  always_comb begin
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rptr_q[AW-1:0];
      valid_o[i] = {1'b0, off} < count;
      mem_o[i*W +: W] = mem_q[i];
    end
  end
  always_ff @(posedge clk)
    if (push_i) mem_q[wptr_q[AW-1:0]] <= data_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i) rptr_q <= rptr_q + 1'b1;
    end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU results and load returns into one register-file write per cycle,
// tracking outstanding loads in a busy scoreboard
module reg_writeback #(
  parameter int DATA_W = reg_writeback_pkg::DATA_W,
  parameter int ADDR_W = reg_writeback_pkg::ADDR_W,
  parameter int ALU_FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_issue_valid,
  output logic              ld_issue_ready,
  input  logic [ADDR_W-1:0] ld_issue_dest,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_dest,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              fwd_rs_hit,
  output logic              fwd_rt_hit,
  output logic              wb_ena,
  output logic [ADDR_W-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              err_spurious
);
  import reg_writeback_pkg::*;
  localparam int NREG = 1 << ADDR_W;
  localparam int EW = ADDR_W + DATA_W;
  logic [NREG-1:0] busy_q, busy_d;
  logic wb_ena_q, wb_ena_d, err_q;
  logic [ADDR_W-1:0] wb_reg_q, sel_dest;
  logic [DATA_W-1:0] wb_data_q, sel_data;
  logic full, empty, pop, push, bypass, alu_acc, iss_acc, sel_v, fifo_hit;
  logic [EW-1:0] head;
  logic [ALU_FIFO_DEPTH-1:0] fvalid;
  logic [ALU_FIFO_DEPTH*EW-1:0] fmem;
  wb_alu_fifo #(.W(EW), .DEPTH(ALU_FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .data_i({alu_dest, alu_data}),
    .data_o(head), .full_o(full), .empty_o(empty), .valid_o(fvalid), .mem_o(fmem)
  );
  // a pop frees a slot the same cycle, so a full FIFO may still accept when loads are idle
  assign pop = !ld_valid && !empty;
  assign alu_ready = (!full || pop) && !busy_q[alu_dest];
  assign alu_acc = alu_valid && alu_ready;
  assign bypass = alu_acc && !ld_valid && empty;
  assign push = alu_acc && !bypass;
  always_comb begin
    fifo_hit = 1'b0;
    for (int i = 0; i < ALU_FIFO_DEPTH; i++)
      fifo_hit = fifo_hit | (fvalid[i] && fmem[i*EW+DATA_W +: ADDR_W] == ld_issue_dest);
  end
  assign ld_issue_ready = !busy_q[ld_issue_dest] && !fifo_hit && !(alu_valid && alu_dest == ld_issue_dest);
  assign iss_acc = ld_issue_valid && ld_issue_ready;
  assign sel_v = ld_valid || !empty || alu_acc;
  assign {sel_dest, sel_data} = ld_valid ? {ld_dest, ld_data} : !empty ? head : {alu_dest, alu_data};
  assign wb_ena_d = sel_v && sel_dest != REG_ZERO;
  always_comb begin
    busy_d = busy_q;
    if (ld_valid) busy_d[ld_dest] = 1'b0;
    if (iss_acc) busy_d[ld_issue_dest] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy_q <= '0;
      wb_ena_q <= 1'b0;
      wb_reg_q <= '0;
      wb_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      wb_ena_q <= wb_ena_d;
      if (wb_ena_d) begin
        wb_reg_q <= sel_dest;
        wb_data_q <= sel_data;
      end
      err_q <= err_q | (ld_valid && !busy_q[ld_dest]);
    end
  assign rs_busy = busy_q[rs_addr];
  assign rt_busy = busy_q[rt_addr];
  assign fwd_rs_hit = wb_ena_q && wb_reg_q == rs_addr && rs_addr != REG_ZERO;
  assign fwd_rt_hit = wb_ena_q && wb_reg_q == rt_addr && rt_addr != REG_ZERO;
  assign wb_ena = wb_ena_q;
  assign wb_reg = wb_reg_q;
  assign wb_data = wb_data_q;
  assign err_spurious = err_q;
endmodule
